truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

- Sequencer that exhaustively sweeps a registered 4-input boolean datapath through minterms 0..15.
- Captures each registered output into a 16-bit truth table and compares it against an expected table, counting mismatching minterms.
- Sits in front of the simplified-function + D flip-flop blocks of the R02 set.
- Replaces hand-written per-minterm stimulus with a one-pulse start/done self-check.

## Interface

- LAT, default 1: edges from `abcd` change to stable `f_out`.
  - 1 = function registered by a single D flip-flop.
  - Legal range 1..4.
- clk  in  1  rising-edge clock, shared with the datapath under test
- clear_n  in  1  asynchronous, active-low reset
- start  in  1  sweep request; sampled on a rising edge in IDLE or DONE
- expected  in  16  golden truth table; bit m = required output for minterm m
- f_out  in  1  registered output of the datapath under test
- abcd  out  4  datapath inputs {a,b,c,d}; a is MSB, value = minterm index
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- table  out  16  captured truth table; bit m = f_out for minterm m
- err_count  out  5  popcount(table ^ expected), range 0..16
- mismatch  out  1  err_count != 0

## Operation

States: IDLE, SWEEP, DRAIN, DONE.

- **IDLE**
  - start=1 at edge S: `expected` latched into an internal copy.
  - table, err_count and mismatch cleared.
  - abcd<=0, busy<=1, go to SWEEP.
- **SWEEP**
  - abcd increments by 1 every cycle, 0..15.
  - The edge that would wrap abcd from 15 goes to DRAIN; abcd holds 15.
- **DRAIN**
  - Lasts LAT cycles.
  - abcd holds 15.
  - Outstanding captures complete here.
- **Capture rule**
  - f_out for minterm m is sampled at edge E_m+LAT+1, where E_m is the edge that drove abcd=m.
  - The sampled bit is written to table[m].
  - If it differs from expected_latched[m], err_count increments.
  - A delay line of depth LAT+1 carries (valid, index); no other bookkeeping.
- **DONE**
  - Entered on the edge that captures minterm 15: busy<=0, done<=1 for exactly one cycle.
  - Next edge: go to IDLE unless start=1, in which case a new sweep begins directly (same actions as IDLE).
- **Result hold:** table, err_count and mismatch stay stable from DONE until the next accepted start.
- **Ignored inputs**
  - start is ignored while busy=1.
  - `expected` changes after S are ignored.
- **Arithmetic**
  - err_count is 5 bits; the maximum of 16 cannot overflow.
  - mismatch is combinational from err_count.

## Timing

- Reset (clear_n=0, asynchronous, any state including mid-sweep), all immediate, no clock required:
  - state=IDLE, abcd=0, busy=0, done=0, table=0, err_count=0, mismatch=0.
  - Delay line valids cleared.
- Release: first start is sampled at the first rising edge with clear_n=1.
- Relative to start edge S:
  - abcd=m during cycle S+m, for m=0..15.
  - busy high from S to S+16+LAT.
  - done high in the cycle following edge S+16+LAT.
  - LAT=1: done 17 cycles after S; total sweep latency 16+LAT cycles.
- Back-to-back sweeps: start held high during DONE gives a gap of 0 idle cycles between sweeps.
- table[m] is updated only at its capture edge; partial tables are visible while busy=1 and carry no meaning.

## Test plan

- **Reset:** assert clear_n=0 mid-cycle with no clock.
  - Required: all outputs 0 immediately.
  - start=0 for 20 cycles keeps busy=0 and done=0.
- **Golden sweep, LAT=1:** f_out from a D flip-flop on (C|D)&(A|B|C)&(~A|B|C)&(~B|~C|~D)&(~A|B|D), expected=16'h686C, start pulsed at S.
  - Required: abcd counts 0..15 in cycles S..S+15.
  - Required: done in cycle after S+17, table=16'h686C, err_count=0, mismatch=0.
- **Mismatch count:** same datapath, expected=16'h0000.
  - Required: table=16'h686C, err_count=7, mismatch=1.
- **Saturation:** f_out tied to 1, expected=16'h0000.
  - Required: table=16'hFFFF, err_count=16.
  - Repeat with LAT=3 and a 3-stage delay on f_out: identical result, done at S+19.
- **Ignored inputs:** pulse start at S+5 and S+10; change expected to 16'hFFFF at S+3.
  - Required: single sweep, done exactly once at S+17, results as in the golden-sweep scenario.
  - Hold start=1 through DONE: second sweep begins with abcd=0 in the cycle after DONE.
- **Reset mid-sweep:** drop clear_n while abcd=7.
  - Required: outputs 0 at once, no done pulse.
  - Next start: a full 0..15 sweep with correct table=16'h686C.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps a registered 4-input datapath through minterms 0..15,
// captures its truth table and counts minterms that differ from a golden table.
module truth_table_scanner #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_out,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  err_count,
    output logic        mismatch
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   abcd_q, abcd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [15:0]  table_q, table_d;
    logic [15:0]  exp_q, exp_d;
    logic [4:0]   err_q, err_d;
    logic [LAT:0] dv_q, dv_d;
    logic [3:0]   di_q [LAT+1];
    logic [3:0]   di_d [LAT+1];

    logic         push_v;
    logic [3:0]   push_i;
    logic         cap_v;
    logic [3:0]   cap_i;

    // Oldest delay-line slot: the minterm whose registered result is on f_out now.
    assign cap_v = dv_q[LAT];
    assign cap_i = di_q[LAT];

    always_comb begin
        // NOTE: every _d gets its default first, so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        abcd_d  = abcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        exp_d   = exp_q;
        err_d   = err_q;
        push_v  = 1'b0;
        push_i  = 4'd0;

        if (cap_v) begin
            table_d[cap_i] = f_out;
            if (f_out != exp_q[cap_i]) err_d = err_q + 5'd1;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    exp_d   = expected;
                    table_d = '0;
                    err_d   = '0;
                    abcd_d  = 4'd0;
                    busy_d  = 1'b1;
                    push_v  = 1'b1;
                    push_i  = 4'd0;
                    state_d = SWEEP;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (abcd_q == 4'd15) begin
                    state_d = DRAIN;
                end else begin
                    abcd_d = abcd_q + 4'd1;
                    push_v = 1'b1;
                    push_i = abcd_q + 4'd1;
                end
            end
            DRAIN: begin
                if (cap_v && cap_i == 4'd15) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        dv_d    = {dv_q[LAT-1:0], push_v};
        di_d[0] = push_i;
        for (int k = 1; k <= LAT; k++) di_d[k] = di_q[k-1];
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            dv_q    <= '0;
            // NOTE: indices mean nothing without their valid bit, but they are cleared too so reset leaves no X behind.
            for (int k = 0; k <= LAT; k++) di_q[k] <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q <= state_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            for (int k = 0; k <= LAT; k++) di_q[k] <= di_d[k];
        end
    end

    assign abcd        = abcd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign err_count   = err_q;
    assign mismatch    = (err_q != 5'd0);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: one LAT=1 and one LAT=3 instance, each in front of a
// registered boolean datapath, checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic clear_n = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic [15:0] exp_v   [2];
    logic        mode_v  [2];   // 0: boolean function, 1: tied high
    logic [3:0]  abcd_o  [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [15:0] tbl_o   [2];
    logic [4:0]  err_o   [2];
    logic        mis_o   [2];

    logic       f0_q = 1'b0;
    logic [2:0] f1_q = 3'b000;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic fn(input logic [3:0] m);
        logic a, b, c, d;
        {a, b, c, d} = m;
        return (c | d) & (a | b | c) & (~a | b | c) & (~b | ~c | ~d) & (~a | b | d);
    endfunction

    function automatic logic [15:0] model_table(input logic mode);
        logic [15:0] t;
        for (int m = 0; m < 16; m++) t[m] = mode ? 1'b1 : fn(4'(m));
        return t;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Datapaths under test: one flop for LAT=1, three for LAT=3.
    always @(posedge clk) begin
        f0_q <= mode_v[0] ? 1'b1 : fn(abcd_o[0]);
        f1_q <= {f1_q[1:0], (mode_v[1] ? 1'b1 : fn(abcd_o[1]))};
    end

    truth_table_scanner #(.LAT(1)) dut0 (
        .clk(clk), .clear_n(clear_n), .start(start_v[0]), .expected(exp_v[0]),
        .f_out(f0_q), .abcd(abcd_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .truth_table(tbl_o[0]), .err_count(err_o[0]), .mismatch(mis_o[0])
    );

    truth_table_scanner #(.LAT(3)) dut1 (
        .clk(clk), .clear_n(clear_n), .start(start_v[1]), .expected(exp_v[1]),
        .f_out(f1_q[2]), .abcd(abcd_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .truth_table(tbl_o[1]), .err_count(err_o[1]), .mismatch(mis_o[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, got, want, cyc);
        end
    endtask

    // Timeline model: a sweep accepted at edge s ends at edge s+16+LAT; results come
    // straight from the boolean function and the expected table latched at s.
    logic        m_active [2];
    int          m_s      [2];
    int          m_done   [2];
    logic [15:0] m_exp    [2];
    logic        m_mode   [2];
    logic [15:0] m_tbl    [2];
    logic [4:0]  m_err    [2];
    logic [3:0]  m_hold   [2];
    int          done_cnt [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_s[i] = 0; m_done[i] = -100; m_exp[i] = '0;
            m_mode[i] = 1'b0; m_tbl[i] = '0; m_err[i] = '0; m_hold[i] = '0; done_cnt[i] = 0;
        end
    end

    always @(negedge clear_n) begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_done[i] = -100; m_tbl[i] = '0; m_err[i] = '0; m_hold[i] = '0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (clear_n) begin
            for (int i = 0; i < 2; i++) begin
                if (m_active[i]) begin
                    if (cyc - m_s[i] == 16 + lat_of(i)) begin
                        m_active[i] = 1'b0;
                        m_done[i]   = cyc;
                        m_hold[i]   = 4'd15;
                        m_tbl[i]    = model_table(m_mode[i]);
                        m_err[i]    = 5'($countones(m_tbl[i] ^ m_exp[i]));
                    end
                end else if (start_v[i]) begin
                    m_active[i] = 1'b1;
                    m_s[i]      = cyc;
                    m_exp[i]    = exp_v[i];
                    m_mode[i]   = mode_v[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clear_n) begin
            for (int i = 0; i < 2; i++) begin
                if (done_o[i]) done_cnt[i]++;
                if (m_active[i]) begin
                    int off;
                    off = cyc - m_s[i];
                    check("cyc_abcd", 32'(abcd_o[i]), (off > 15) ? 32'd15 : 32'(off));
                    check("cyc_busy", 32'(busy_o[i]), 32'd1);
                    check("cyc_done", 32'(done_o[i]), 32'd0);
                end else begin
                    check("cyc_busy", 32'(busy_o[i]), 32'd0);
                    check("cyc_done", 32'(done_o[i]), (cyc == m_done[i]) ? 32'd1 : 32'd0);
                    check("cyc_abcd", 32'(abcd_o[i]), 32'(m_hold[i]));
                    check("cyc_table", 32'(tbl_o[i]), 32'(m_tbl[i]));
                    check("cyc_err", 32'(err_o[i]), 32'(m_err[i]));
                    check("cyc_mismatch", 32'(mis_o[i]), (m_err[i] != 0) ? 32'd1 : 32'd0);
                end
            end
        end
    end

    task automatic check_zero(input string name, input int i);
        check({name, "_abcd"}, 32'(abcd_o[i]), 32'd0);
        check({name, "_busy"}, 32'(busy_o[i]), 32'd0);
        check({name, "_done"}, 32'(done_o[i]), 32'd0);
        check({name, "_table"}, 32'(tbl_o[i]), 32'd0);
        check({name, "_err"}, 32'(err_o[i]), 32'd0);
        check({name, "_mismatch"}, 32'(mis_o[i]), 32'd0);
    endtask

    // Returns at the falling edge just before rising edge e.
    task automatic to_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic pulse_start(input int i, input logic [15:0] ex, input logic mode, output int s);
        start_v[i] = 1'b1;
        exp_v[i]   = ex;
        mode_v[i]  = mode;
        s          = cyc + 1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int e);
        bit seen;
        seen = 1'b0;
        e    = -1;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (done_o[i]) begin
                seen = 1'b1;
                e    = cyc;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string name, input int i, input logic [15:0] t, input logic [4:0] er);
        check({name, "_table"}, 32'(tbl_o[i]), 32'(t));
        check({name, "_err"}, 32'(err_o[i]), 32'(er));
        check({name, "_mismatch"}, 32'(mis_o[i]), (er != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int s, e, e1, cnt;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; exp_v[i] = '0; mode_v[i] = 1'b0;
        end

        // Reset with no clock edge yet.
        #2 clear_n = 1'b0;
        #1 check_zero("reset", 0);
        check_zero("reset", 1);
        @(negedge clk);
        clear_n = 1'b1;
        repeat (20) @(negedge clk);

        check("model_pin", 32'(model_table(1'b0)), 32'h686C);

        // Golden sweep, LAT=1.
        pulse_start(0, 16'h686C, 1'b0, s);
        wait_done(0, e);
        check("gold_done_at", 32'(e - s), 32'd17);
        check_result("gold", 0, 16'h686C, 5'd0);

        // Mismatch count.
        repeat (2) @(negedge clk);
        pulse_start(0, 16'h0000, 1'b0, s);
        wait_done(0, e);
        check_result("mism", 0, 16'h686C, 5'd7);

        // Saturation on both instances.
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1; exp_v[0] = 16'h0000; mode_v[0] = 1'b1;
        start_v[1] = 1'b1; exp_v[1] = 16'h0000; mode_v[1] = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        wait_done(0, e);
        check("sat1_done_at", 32'(e - s), 32'd17);
        check_result("sat1", 0, 16'hFFFF, 5'd16);
        wait_done(1, e1);
        check("sat3_done_at", 32'(e1 - s), 32'd19);
        check_result("sat3", 1, 16'hFFFF, 5'd16);

        // Ignored start/expected while busy, then start held through DONE.
        repeat (2) @(negedge clk);
        #1 cnt = done_cnt[0];
        @(negedge clk);
        pulse_start(0, 16'h686C, 1'b0, s);
        to_edge(s + 3); exp_v[0] = 16'hFFFF;
        to_edge(s + 5); start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        to_edge(s + 10); start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        to_edge(s + 16); start_v[0] = 1'b1;
        wait_done(0, e);
        check("ign_done_at", 32'(e - s), 32'd17);
        check_result("ign", 0, 16'h686C, 5'd0);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("b2b_abcd0", 32'(abcd_o[0]), 32'd0);
        check("b2b_busy", 32'(busy_o[0]), 32'd1);
        wait_done(0, e);
        check("b2b_done_at", 32'(e - s), 32'd35);
        check_result("b2b", 0, 16'h686C, 5'd9);
        #1 check("ign_done_count", 32'(done_cnt[0] - cnt), 32'd2);

        // Reset in the middle of a sweep.
        repeat (2) @(negedge clk);
        pulse_start(0, 16'h686C, 1'b0, s);
        to_edge(s + 7);
        @(posedge clk);
        #1 check("rst_mid_abcd7", 32'(abcd_o[0]), 32'd7);
        #1 clear_n = 1'b0;
        #1 check_zero("rst_mid", 0);
        check_zero("rst_mid", 1);
        cnt = done_cnt[0];
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        repeat (20) @(negedge clk);
        #1 check("rst_mid_no_done", 32'(done_cnt[0] - cnt), 32'd0);
        @(negedge clk);
        pulse_start(0, 16'h686C, 1'b0, s);
        wait_done(0, e);
        check("rst_resweep_done_at", 32'(e - s), 32'd17);
        check_result("rst_resweep", 0, 16'h686C, 5'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
